// File: rtl/fpga_clk_reconf_ctrl.sv
// MMCM dynamic reconfiguration controller: turns SoC divider writes into CLKOUTn DRP writes
// and sequences MMCM reset / re-lock. Optional DRP read-back verify: FPGA_CLK_RECONF_RB_EN.
module fpga_clk_reconf_ctrl #(
    parameter logic [7:0]  SOC_DIV_INIT  = 8'd4,
    parameter logic [7:0]  PER_DIV_INIT  = 8'd8,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter logic [6:0]  DRP_ADDR_OUT0 = 7'h08,
    parameter logic [6:0]  DRP_ADDR_OUT1 = 7'h0A
) (
    input  logic        ref_clk_i,
    input  logic        rstn_glob_i,
    input  logic        cfg_req_i,
    output logic        cfg_ack_o,
    input  logic [1:0]  cfg_add_i,
    input  logic        cfg_wen_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        mmcm_rst_o,
    input  logic        mmcm_locked_i,
    output logic        clk_rstn_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WR1, S_WR2, S_REL, S_LOCK, S_RB1, S_RB2
    } state_t;

    function automatic logic [7:0] sat_div(input logic [7:0] d);
        logic [7:0] r;
        if (d == 8'd0)        r = 8'd1;
        else if (d > 8'd126)  r = 8'd126;
        else                  r = d;
        return r;
    endfunction

    state_t      state_reg, state_next;
    logic        ack_reg, ack_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        den_reg, den_next;
    logic        dwe_reg, dwe_next;
    logic [6:0]  daddr_reg, daddr_next;
    logic [15:0] di_reg, di_next;
    logic        rst_reg, rst_next;
    logic [31:0] lock_cnt_reg, lock_cnt_next;
    logic        error_reg, error_next;
    logic        clk_rstn_reg;
    logic [7:0]  soc_div_reg, per_div_reg;
    logic        out_sel_reg;

    logic        req_take, rd_take, wr_take, start, stat_clr, err_set;
    logic [7:0]  new_div, div_sel;
    logic [6:0]  drp_base;
    logic [15:0] clk_reg1, clk_reg2;
    logic        no_count;
    logic [31:0] rd_val;
    logic        unused_inputs;

    // ack_reg blocks the request still held high during its own ack cycle
    assign req_take = cfg_req_i & ~ack_reg;
    assign rd_take  = req_take & cfg_wen_i;
    assign wr_take  = req_take & ~cfg_wen_i;
    assign start    = wr_take & ~cfg_add_i[1] & (state_reg == S_IDLE);
    assign stat_clr = rd_take & (cfg_add_i == 2'd2);
    assign new_div  = sat_div(cfg_wdata_i[7:0]);

    assign div_sel  = out_sel_reg ? per_div_reg : soc_div_reg;
    assign drp_base = out_sel_reg ? DRP_ADDR_OUT1 : DRP_ADDR_OUT0;
    assign no_count = (div_sel == 8'd1);
    assign clk_reg1 = {4'b0000, div_sel[6:1], 6'(div_sel - {1'b0, div_sel[7:1]})};
    // Divide-by-1 bypasses the counter, so the half-cycle edge bit is meaningless and kept 0
    assign clk_reg2 = {8'h00, div_sel[0] & ~no_count, no_count, 6'b000000};

    always_comb begin
        rd_val = 32'd0;
        case (cfg_add_i)
            2'd0:    rd_val = {24'd0, soc_div_reg};
            2'd1:    rd_val = {24'd0, per_div_reg};
            2'd2:    rd_val = {29'd0, error_reg | err_set, mmcm_locked_i, state_reg != S_IDLE};
            default: rd_val = 32'd0;
        endcase
    end

    assign ack_next   = rd_take | (wr_take & cfg_add_i[1]) | start;
    assign rdata_next = rd_take ? rd_val : 32'd0;
    // A setting event wins over a concurrent status-read clear
    assign error_next = err_set | (error_reg & ~stat_clr);

    always_comb begin
        state_next    = state_reg;
        den_next      = 1'b0;
        dwe_next      = 1'b0;
        daddr_next    = daddr_reg;
        di_next       = di_reg;
        rst_next      = rst_reg;
        lock_cnt_next = lock_cnt_reg;
        err_set       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RST;
                    rst_next   = 1'b1;
                end
            end
            S_RST: begin
                state_next = S_WR1;
                den_next   = 1'b1;
                dwe_next   = 1'b1;
                daddr_next = drp_base;
                di_next    = clk_reg1;
            end
            S_WR1: begin
                if (drp_drdy_i && !den_reg) begin
`ifdef FPGA_CLK_RECONF_RB_EN
                    state_next = S_RB1;
                    den_next   = 1'b1;
`else
                    state_next = S_WR2;
                    den_next   = 1'b1;
                    dwe_next   = 1'b1;
                    daddr_next = 7'(drp_base + 7'd1);
                    di_next    = clk_reg2;
`endif
                end
            end
`ifdef FPGA_CLK_RECONF_RB_EN
            S_RB1: begin
                if (drp_drdy_i && !den_reg) begin
                    err_set    = (drp_do_i != di_reg);
                    state_next = S_WR2;
                    den_next   = 1'b1;
                    dwe_next   = 1'b1;
                    daddr_next = 7'(drp_base + 7'd1);
                    di_next    = clk_reg2;
                end
            end
            S_RB2: begin
                if (drp_drdy_i && !den_reg) begin
                    err_set    = (drp_do_i != di_reg);
                    state_next = S_REL;
                    rst_next   = 1'b0;
                end
            end
`endif
            S_WR2: begin
                if (drp_drdy_i && !den_reg) begin
`ifdef FPGA_CLK_RECONF_RB_EN
                    state_next = S_RB2;
                    den_next   = 1'b1;
`else
                    state_next = S_REL;
                    rst_next   = 1'b0;
`endif
                end
            end
            S_REL: begin
                state_next    = S_LOCK;
                lock_cnt_next = 32'd0;
            end
            S_LOCK: begin
                if (mmcm_locked_i) begin
                    state_next = S_IDLE;
                end else if (lock_cnt_reg == LOCK_TIMEOUT) begin
                    err_set    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 32'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            state_reg    <= S_IDLE;
            ack_reg      <= 1'b0;
            rdata_reg    <= 32'd0;
            den_reg      <= 1'b0;
            dwe_reg      <= 1'b0;
            daddr_reg    <= 7'd0;
            di_reg       <= 16'd0;
            rst_reg      <= 1'b0;
            lock_cnt_reg <= 32'd0;
            error_reg    <= 1'b0;
            clk_rstn_reg <= 1'b0;
            soc_div_reg  <= SOC_DIV_INIT;
            per_div_reg  <= PER_DIV_INIT;
            out_sel_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            rdata_reg    <= rdata_next;
            den_reg      <= den_next;
            dwe_reg      <= dwe_next;
            daddr_reg    <= daddr_next;
            di_reg       <= di_next;
            rst_reg      <= rst_next;
            lock_cnt_reg <= lock_cnt_next;
            error_reg    <= error_next;
            clk_rstn_reg <= mmcm_locked_i & (state_reg == S_IDLE) & ~rst_reg;
            if (start) begin
                out_sel_reg <= cfg_add_i[0];
                if (cfg_add_i[0]) per_div_reg <= new_div;
                else              soc_div_reg <= new_div;
            end
        end
    end

`ifdef FPGA_CLK_RECONF_RB_EN
    assign unused_inputs = ^cfg_wdata_i[31:8];
`else
    assign unused_inputs = ^{cfg_wdata_i[31:8], drp_do_i};
`endif

    assign cfg_ack_o   = ack_reg;
    assign cfg_rdata_o = rdata_reg;
    assign drp_den_o   = den_reg;
    assign drp_dwe_o   = dwe_reg;
    assign drp_daddr_o = daddr_reg;
    assign drp_di_o    = di_reg;
    assign mmcm_rst_o  = rst_reg;
    assign clk_rstn_o  = clk_rstn_reg;

endmodule
